ept_uc_stream_bridge: RTL
=========================

# ept_uc_stream_bridge

User-side stream bridge between the USB endpoint transfer layer and the KIM-1 application logic. It buffers host-to-device bytes addressed to one endpoint in a receive FIFO, and buffers device-to-host bytes in a transmit FIFO. It drains the transmit FIFO one byte at a time through a request/done handshake with the endpoint layer. It sits directly downstream of the endpoint register block, on the user-code side.

## Interface
Parameters:
- DEPTH_LOG2, 4: log2 of each FIFO depth; 16 entries by default.
- EP_ADDR, 3'd2: endpoint address accepted on receive and driven on transmit.
- TX_TIMEOUT, 1023: cycles to wait for EP_TX_DONE before abandoning a request.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- CLK  in  1  system clock; all logic is rising-edge.
- RST  in  1  asynchronous, active-high reset.
- EP_RX_STROBE  in  1  one-cycle pulse; a host byte is valid this cycle.
- EP_RX_ADDR  in  3  endpoint address of that byte.
- EP_RX_BYTE  in  8  host byte.
- EP_TX_REQ  out  1  request to send EP_TX_BYTE to the host.
- EP_TX_ADDR  out  3  constant EP_ADDR.
- EP_TX_BYTE  out  8  head of the transmit FIFO.
- EP_TX_BUSY  in  1  endpoint layer is mid-transfer; do not raise a new request.
- EP_TX_DONE  in  1  one-cycle pulse; the requested byte has been taken.
- RD_EN  in  1  pop the receive FIFO.
- RD_DATA  out  8  popped byte.
- RD_VALID  out  1  RD_DATA is valid; one-cycle pulse.
- RX_EMPTY  out  1  receive FIFO is empty.
- RX_COUNT  out  DEPTH_LOG2+1  receive occupancy.
- RX_OVERFLOW  out  1  sticky; a byte was dropped because the FIFO was full.
- WR_EN  in  1  push WR_DATA into the transmit FIFO.
- WR_DATA  in  8  byte to send to the host.
- TX_FULL  out  1  transmit FIFO is full.
- TX_COUNT  out  DEPTH_LOG2+1  transmit occupancy.
- TX_TIMEOUT_ERR  out  1  sticky; a request timed out.
- CLR_ERR  in  1  clears both sticky flags.

## Operation
- Receive push condition: EP_RX_STROBE && EP_RX_ADDR==EP_ADDR.
  - Bytes with any other address are ignored.
  - Push while full (full judged on the pre-edge count, with no simultaneous pop): the byte is dropped and RX_OVERFLOW is set.
  - Push and pop in the same cycle while full: both happen and the count is unchanged.
- Receive pop:
  - RD_EN while not empty: RD_DATA is loaded and RD_VALID pulses the next cycle.
  - RD_EN while empty is ignored; RD_VALID stays 0 and RD_DATA holds its last value.
- Transmit push:
  - WR_EN while not full pushes WR_DATA.
  - WR_EN while full drops the byte silently; the producer must check TX_FULL.
  - Push and pop in the same cycle while full are both honoured.
- Transmit FSM, states IDLE, REQ, BACKOFF:
  - IDLE: when TX_COUNT!=0 and !EP_TX_BUSY, go to REQ and clear the timer.
  - REQ: EP_TX_REQ=1 and EP_TX_BYTE=FIFO head, both held stable.
    - On EP_TX_DONE: pop the head and go to IDLE.
    - When the timer reaches TX_TIMEOUT without EP_TX_DONE: set TX_TIMEOUT_ERR, do not pop, go to BACKOFF.
  - BACKOFF: stay one cycle with EP_TX_REQ=0, then go to IDLE. The same byte is retried.
  - EP_TX_DONE outside REQ is ignored.
- CLR_ERR in the same cycle as a setting event: the set wins.
- Counters are DEPTH_LOG2+1 bits; pointers are DEPTH_LOG2 bits and wrap modulo the depth.
- Reset values:
  - EP_TX_REQ=0, EP_TX_BYTE=0, EP_TX_ADDR=EP_ADDR.
  - RD_DATA=0, RD_VALID=0, RX_EMPTY=1, RX_COUNT=0, RX_OVERFLOW=0.
  - TX_FULL=0, TX_COUNT=0, TX_TIMEOUT_ERR=0.
  - FSM=IDLE; both FIFOs are emptied.
- Reset asserted mid-request: EP_TX_REQ drops asynchronously and the in-flight byte is discarded.

## Timing
- Receive strobe at edge N: RX_COUNT and RX_EMPTY update after edge N.
- RD_EN at edge N: RD_DATA and RD_VALID are valid after edge N.
- WR_EN into an empty transmit FIFO at edge N:
  - TX_COUNT=1 after N.
  - FSM enters REQ at N+1, so EP_TX_REQ is high after N+1.
- EP_TX_DONE at edge M: EP_TX_REQ is low and TX_COUNT is decremented after M.
  - The next request rises after M+1 at the earliest, guaranteeing one low cycle between bytes.
- Timeout: EP_TX_REQ is high for exactly TX_TIMEOUT+1 cycles, then low for 2 cycles (BACKOFF and IDLE) before the retry.
- All outputs are registered; there are no combinational in-to-out paths.

## Structure
- Package ept_uc_pkg holds:
  - the endpoint address width (3);
  - the byte width (8);
  - the TX FSM state encoding: IDLE=2'd0, REQ=2'd1, BACKOFF=2'd2;
  - the default DEPTH_LOG2.
- One sub-module, ept_sync_fifo, instantiated twice:
  - parameterised on width and DEPTH_LOG2;
  - registered read data, with count, full and empty outputs.
- The top level holds the address filter, the TX FSM, the timeout counter and the sticky flags.

## Test plan
- Reset, then 16 strobes at EP_ADDR with bytes 0x00..0x0F, then a 17th strobe with 0xAA -> RX_COUNT=16, RX_OVERFLOW=1; 16 RD_EN pops return 0x00..0x0F in order, then RX_EMPTY=1.
- Strobe with EP_RX_ADDR=3'd5 -> RX_COUNT remains 0.
- WR_EN 0x41, 0x42; bench pulses EP_TX_DONE 3 cycles after each request -> EP_TX_BYTE shows 0x41 then 0x42, at least one low cycle between requests, TX_COUNT ends at 0.
- EP_TX_BUSY held high with TX_COUNT=1 -> EP_TX_REQ stays 0; release BUSY -> EP_TX_REQ=1 on the next cycle.
- TX_TIMEOUT=7 with no EP_TX_DONE -> REQ high 8 cycles, TX_TIMEOUT_ERR=1, same byte re-requested, TX_COUNT stays 1; CLR_ERR -> flag 0.
- RST pulsed while EP_TX_REQ=1 and both FIFOs hold 4 bytes -> EP_TX_REQ=0 immediately; after reset both counts are 0 and RX_EMPTY=1.

Source files
------------

// File: rtl/ept_uc_pkg.sv
`default_nettype none
// ==========================================================================
// ept_uc_pkg - shared widths and TX state encoding for the endpoint bridge.
// Revision 1.0
// ==========================================================================
package ept_uc_pkg;

  localparam int ADDR_W             = 3;
  localparam int BYTE_W             = 8;
  localparam int DEFAULT_DEPTH_LOG2 = 4;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_REQ     = 2'd1,
    TX_BACKOFF = 2'd2
  } tx_state_e;

endpackage : ept_uc_pkg
`default_nettype wire

// File: rtl/ept_sync_fifo.sv
`default_nettype none
// ==========================================================================
// ept_sync_fifo - synchronous FIFO with registered read port and occupancy.
// Revision 1.0
// ==========================================================================
module ept_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  rvalid_o,
  output logic [WIDTH-1:0]      head_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_d;
  logic [WIDTH-1:0]      rdata_q;
  logic                  rvalid_q;
  logic                  push_ok;
  logic                  pop_ok;

  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_i);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rvalid_q <= pop_ok;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rdata_q  <= mem_q[rd_ptr_q];
      end
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign head_o   = mem_q[rd_ptr_q];
  assign count_o  = count_q;
  assign full_o   = (count_q == FULL_CNT);
  assign empty_o  = (count_q == '0);

endmodule : ept_sync_fifo
`default_nettype wire

// File: rtl/ept_uc_stream_bridge.sv
`default_nettype none
// ==========================================================================
// ept_uc_stream_bridge - endpoint RX/TX byte FIFOs with request/done sender.
// Revision 1.0
// ==========================================================================
module ept_uc_stream_bridge
  import ept_uc_pkg::*;
#(
  parameter int                DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter logic [ADDR_W-1:0] EP_ADDR    = 3'd2,
  parameter int                TX_TIMEOUT = 1023
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ep_rx_strobe_i,
  input  logic [ADDR_W-1:0]     ep_rx_addr_i,
  input  logic [BYTE_W-1:0]     ep_rx_byte_i,
  output logic                  ep_tx_req_o,
  output logic [ADDR_W-1:0]     ep_tx_addr_o,
  output logic [BYTE_W-1:0]     ep_tx_byte_o,
  input  logic                  ep_tx_busy_i,
  input  logic                  ep_tx_done_i,
  input  logic                  rd_en_i,
  output logic [BYTE_W-1:0]     rd_data_o,
  output logic                  rd_valid_o,
  output logic                  rx_empty_o,
  output logic [DEPTH_LOG2:0]   rx_count_o,
  output logic                  rx_overflow_o,
  input  logic                  wr_en_i,
  input  logic [BYTE_W-1:0]     wr_data_i,
  output logic                  tx_full_o,
  output logic [DEPTH_LOG2:0]   tx_count_o,
  output logic                  tx_timeout_err_o,
  input  logic                  clr_err_i
);

  localparam int               TMR_W   = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TX_TIMEOUT);

  logic              rx_push;
  logic              rx_full;
  logic              rx_drop;
  logic [BYTE_W-1:0] rx_head;
  logic              tx_pop;
  logic              tx_empty;
  logic [BYTE_W-1:0] tx_head;
  logic [BYTE_W-1:0] tx_rdata;
  logic              tx_rvalid;
  logic              unused_ok;

  tx_state_e         state_q;
  logic [TMR_W-1:0]  timer_q;
  logic              req_q;
  logic [BYTE_W-1:0] byte_q;
  logic              tout_q;
  logic              ovf_q;

  assign rx_push = ep_rx_strobe_i && (ep_rx_addr_i == EP_ADDR);
  assign rx_drop = rx_push && rx_full && !rd_en_i;
  assign tx_pop  = (state_q == TX_REQ) && ep_tx_done_i;

  ept_sync_fifo #(
    .WIDTH      (BYTE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rx_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (rx_push),
    .wdata_i  (ep_rx_byte_i),
    .pop_i    (rd_en_i),
    .rdata_o  (rd_data_o),
    .rvalid_o (rd_valid_o),
    .head_o   (rx_head),
    .count_o  (rx_count_o),
    .full_o   (rx_full),
    .empty_o  (rx_empty_o)
  );

  ept_sync_fifo #(
    .WIDTH      (BYTE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tx_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (wr_en_i),
    .wdata_i  (wr_data_i),
    .pop_i    (tx_pop),
    .rdata_o  (tx_rdata),
    .rvalid_o (tx_rvalid),
    .head_o   (tx_head),
    .count_o  (tx_count_o),
    .full_o   (tx_full_o),
    .empty_o  (tx_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (rx_drop) begin
      ovf_q <= 1'b1;
    end else if (clr_err_i) begin
      ovf_q <= 1'b0;
    end
  end

  // The timeout flag shares this block so a same-cycle set overrides the clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= TX_IDLE;
      timer_q <= '0;
      req_q   <= 1'b0;
      byte_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      if (clr_err_i) begin
        tout_q <= 1'b0;
      end
      case (state_q)
        TX_IDLE: begin
          if (!tx_empty && !ep_tx_busy_i) begin
            state_q <= TX_REQ;
            timer_q <= '0;
            req_q   <= 1'b1;
            byte_q  <= tx_head;
          end
        end
        TX_REQ: begin
          if (ep_tx_done_i) begin
            state_q <= TX_IDLE;
            req_q   <= 1'b0;
          end else if (timer_q == TMR_MAX) begin
            state_q <= TX_BACKOFF;
            req_q   <= 1'b0;
            tout_q  <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        TX_BACKOFF: begin
          state_q <= TX_IDLE;
        end
        default: begin
          state_q <= TX_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ep_tx_req_o      = req_q;
  assign ep_tx_addr_o     = EP_ADDR;
  assign ep_tx_byte_o     = byte_q;
  assign rx_overflow_o    = ovf_q;
  assign tx_timeout_err_o = tout_q;

  assign unused_ok = ^{tx_rdata, tx_rvalid, rx_head};

endmodule : ept_uc_stream_bridge
`default_nettype wire
